// File: rtl/rfsoc_config.sv
// Shared RFSoC configuration: sequencer state encoding and default config register width.
package rfsoc_config;

  localparam int CONFIG_REG_WIDTH = 32;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_PRE  = 3'd1,
    SEQ_RUN  = 3'd2,
    SEQ_POST = 3'd3,
    SEQ_DONE = 3'd4
  } seq_state_e;

endpackage

// File: rtl/dac_seq_ctrl.sv
// DAC playback sequencer: trigger -> PRE delay -> RUN (FIFO reads) -> POST delay -> DONE pulse.
// Optional macro DAC_SEQ_LOCK_WAVE_EN adds lock_play (high in IDLE, forces dac_unmask).
module dac_seq_ctrl
  import rfsoc_config::*;
#(
  parameter int CNT_W = CONFIG_REG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [CNT_W-1:0] pre_delay,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] post_delay,
  input  logic             mask_en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             dac_unmask,
  output logic             fifo_rewind,
  output logic             busy,
  output logic             done,
  output logic             underrun
`ifdef DAC_SEQ_LOCK_WAVE_EN
  ,
  output logic             lock_play
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pre_q, pre_d, run_q, run_d, post_q, post_d;
  logic             mask_q, mask_d;
  logic             trig_q, trig_evt_s;
  logic             rd_en_q, rd_en_d;
  logic             unmask_q, unmask_d;
  logic             rewind_q, rewind_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             force_unmask_s;
`ifdef DAC_SEQ_LOCK_WAVE_EN
  logic             lock_q, lock_d;
`endif

  // Next-state, phase counter, config latch and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    run_d      = run_q;
    post_d     = post_q;
    mask_d     = mask_q;
    underrun_d = underrun_q;
    trig_evt_s = trigger & ~trig_q;

    // cnt holds the cycles remaining in the current phase after this one; empty phases are skipped.
    case (state_q)
      SEQ_IDLE: begin
        if (trig_evt_s) begin
          pre_d      = pre_delay;
          run_d      = run_cycles;
          post_d     = post_delay;
          mask_d     = mask_en;
          underrun_d = 1'b0;
          if (pre_delay != CNT_ZERO) begin
            state_d = SEQ_PRE;
            cnt_d   = pre_delay - CNT_ONE;
          end else if (run_cycles != CNT_ZERO) begin
            state_d = SEQ_RUN;
            cnt_d   = run_cycles - CNT_ONE;
          end else if (post_delay != CNT_ZERO) begin
            state_d = SEQ_POST;
            cnt_d   = post_delay - CNT_ONE;
          end else begin
            state_d = SEQ_DONE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_PRE: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (run_q != CNT_ZERO) begin
          state_d = SEQ_RUN;
          cnt_d   = run_q - CNT_ONE;
        end else if (post_q != CNT_ZERO) begin
          state_d = SEQ_POST;
          cnt_d   = post_q - CNT_ONE;
        end else begin
          state_d = SEQ_DONE;
          cnt_d   = CNT_ZERO;
        end
      end
      SEQ_RUN: begin
        underrun_d = underrun_q | fifo_empty;
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (post_q != CNT_ZERO) begin
          state_d = SEQ_POST;
          cnt_d   = post_q - CNT_ONE;
        end else begin
          state_d = SEQ_DONE;
          cnt_d   = CNT_ZERO;
        end
      end
      SEQ_POST: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = SEQ_DONE;
          cnt_d   = CNT_ZERO;
        end
      end
      SEQ_DONE: begin
        state_d = SEQ_IDLE;
        cnt_d   = CNT_ZERO;
      end
      default: begin
        state_d = SEQ_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    rd_en_d  = (state_d == SEQ_RUN);
    busy_d   = (state_d != SEQ_IDLE);
    done_d   = (state_d == SEQ_DONE);
    rewind_d = (state_d == SEQ_DONE);
`ifdef DAC_SEQ_LOCK_WAVE_EN
    lock_d         = (state_d == SEQ_IDLE);
    force_unmask_s = lock_d;
`else
    force_unmask_s = 1'b0;
`endif
    if (force_unmask_s || (state_d == SEQ_RUN)) begin
      unmask_d = 1'b1;
    end else if (state_d == SEQ_IDLE) begin
      unmask_d = ~mask_en;
    end else begin
      unmask_d = ~mask_d;
    end
  end

  // State, counter, latched config and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      cnt_q      <= CNT_ZERO;
      pre_q      <= CNT_ZERO;
      run_q      <= CNT_ZERO;
      post_q     <= CNT_ZERO;
      mask_q     <= 1'b0;
      trig_q     <= 1'b1;
      rd_en_q    <= 1'b0;
      unmask_q   <= ~mask_en;
      rewind_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef DAC_SEQ_LOCK_WAVE_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      run_q      <= run_d;
      post_q     <= post_d;
      mask_q     <= mask_d;
      trig_q     <= trigger;
      rd_en_q    <= rd_en_d;
      unmask_q   <= unmask_d;
      rewind_q   <= rewind_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
`ifdef DAC_SEQ_LOCK_WAVE_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign dac_unmask  = unmask_q;
  assign fifo_rewind = rewind_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign underrun    = underrun_q;
`ifdef DAC_SEQ_LOCK_WAVE_EN
  assign lock_play   = lock_q;
`endif

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Self-checking bench for dac_seq_ctrl: directed scenarios plus random stimulus vs a timeline model.
module tb_dac_seq_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             trigger;
  logic [CNT_W-1:0] pre_delay, run_cycles, post_delay;
  logic             mask_en;
  logic             fifo_empty;
  logic             fifo_rd_en, dac_unmask, fifo_rewind, busy, done, underrun;
  logic             lock_s;
`ifdef DAC_SEQ_LOCK_WAVE_EN
  logic             lock_play;
  assign lock_s = lock_play;
`else
  assign lock_s = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dac_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .pre_delay  (pre_delay),
    .run_cycles (run_cycles),
    .post_delay (post_delay),
    .mask_en    (mask_en),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .dac_unmask (dac_unmask),
    .fifo_rewind(fifo_rewind),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
`ifdef DAC_SEQ_LOCK_WAVE_EN
    ,
    .lock_play  (lock_play)
`endif
  );

  always #5 clk = ~clk;

  wire [6:0] obs_vec = {busy, fifo_rd_en, done, fifo_rewind, underrun, dac_unmask, lock_s};

  // Timeline model: a sequence is just an offset k (1..p+r+q+1) since the triggering edge.
  bit     m_active = 1'b0, m_hist = 1'b1, m_under = 1'b0, m_rst = 1'b1, m_mask = 1'b0, m_mask_now = 1'b0;
  longint m_k = 0, m_p = 0, m_r = 0, m_q = 0;

  always @(posedge clk) begin
    m_rst      = rst;
    m_mask_now = mask_en;
    if (rst) begin
      m_active = 1'b0;
      m_hist   = 1'b1;
      m_under  = 1'b0;
      m_k      = 0;
    end else begin
      if (m_active) begin
        if (m_k > m_p && m_k <= m_p + m_r && fifo_empty) m_under = 1'b1;
        if (m_k == m_p + m_r + m_q + 1) m_active = 1'b0;
        else m_k = m_k + 1;
      end else if (trigger && !m_hist) begin
        m_active = 1'b1;
        m_k      = 1;
        m_p      = pre_delay;
        m_r      = run_cycles;
        m_q      = post_delay;
        m_mask   = mask_en;
        m_under  = 1'b0;
      end
      m_hist = trigger;
    end
  end

  function automatic logic [6:0] exp_vec();
    logic bz, rd, dn, um, lk;
    bz = m_active;
    rd = m_active && (m_k > m_p) && (m_k <= m_p + m_r);
    dn = m_active && (m_k == m_p + m_r + m_q + 1);
`ifdef DAC_SEQ_LOCK_WAVE_EN
    lk = !m_active && !m_rst;
`else
    lk = 1'b0;
`endif
    if (rd || lk) um = 1'b1;
    else if (m_active) um = !m_mask;
    else um = !m_mask_now;
    return {bz, rd, dn, dn, m_under, um, lk};
  endfunction

  task automatic set_cfg(input longint p, input longint r, input longint q);
    pre_delay  = CNT_W'(p);
    run_cycles = CNT_W'(r);
    post_delay = CNT_W'(q);
  endtask

  task automatic test_reset();
    rst = 1'b1; trigger = 1'b1; mask_en = 1'b1; fifo_empty = 1'b0;
    set_cfg(0, 0, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, fifo_rd_en, done, fifo_rewind, underrun, dac_unmask, lock_s} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_values obs=%b exp=%b", obs_vec, 7'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_held_trigger cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
    end
    trigger = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int rd_cnt = 0, busy_cnt = 0, first_rd = 0, done_at = 0;
    set_cfg(3, 5, 2); mask_en = 1'b1;
    trigger = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL directed cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      if (fifo_rd_en) begin rd_cnt++; if (first_rd == 0) first_rd = i; end
      if (busy) busy_cnt++;
      if (done && fifo_rewind) done_at = i;
      if (i == 2) trigger = 1'b0;
    end
    n_checks++;
    if (first_rd != 4 || rd_cnt != 5 || done_at != 11 || busy_cnt != 11) begin
      n_fail++;
      $display("FAIL directed_timing first_rd=%0d rd=%0d done=%0d busy=%0d exp 4/5/11/11",
               first_rd, rd_cnt, done_at, busy_cnt);
    end
  endtask

  task automatic test_zero_config();
    int rd_cnt = 0, busy_cnt = 0, done_at = 0;
    set_cfg(0, 0, 0);
    trigger = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL zero_cfg cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      if (fifo_rd_en) rd_cnt++;
      if (busy) busy_cnt++;
      if (done) done_at = i;
    end
    trigger = 1'b0;
    n_checks++;
    if (done_at != 1 || rd_cnt != 0 || busy_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_cfg_timing done=%0d rd=%0d busy=%0d exp 1/0/1", done_at, rd_cnt, busy_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_held_trigger();
    int rd_cnt = 0, done_cnt = 0;
    set_cfg(1, 4, 1);
    trigger = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL held_trigger cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      if (fifo_rd_en) rd_cnt++;
      if (done) done_cnt++;
    end
    trigger = 1'b0;
    @(negedge clk);
    // second rise lands mid-RUN and must be ignored
    set_cfg(0, 10, 0);
    trigger = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL retrigger cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      if (fifo_rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (i == 3) trigger = 1'b0;
      if (i == 5) trigger = 1'b1;
    end
    trigger = 1'b0;
    n_checks++;
    if (rd_cnt != 14 || done_cnt != 2) begin
      n_fail++;
      $display("FAIL held_trigger_counts rd=%0d done=%0d exp 14/2", rd_cnt, done_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_underrun();
    int rd_cnt = 0;
    set_cfg(2, 8, 1);
    trigger = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL underrun cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      if (fifo_rd_en) rd_cnt++;
      if (i == 2) trigger = 1'b0;
      fifo_empty = (i == 4);
    end
    n_checks++;
    if (underrun !== 1'b1 || rd_cnt != 8) begin
      n_fail++;
      $display("FAIL underrun_sticky underrun=%b rd=%0d exp 1/8", underrun, rd_cnt);
    end
    set_cfg(0, 2, 0);
    trigger = 1'b1;
    @(negedge clk);
    n_checks++;
    if (underrun !== 1'b0 || obs_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL underrun_clear obs=%b exp=%b", obs_vec, exp_vec());
    end
    trigger = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rd_cnt = 0, done_cnt = 0;
    set_cfg(1, 10, 3);
    trigger = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      if (fifo_rd_en) rd_cnt++;
      if (done || fifo_rewind) done_cnt++;
      if (i == 4) begin
        n_checks++;
        if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_abort busy=%b rd=%b exp 0/0", busy, fifo_rd_en);
        end
      end
      if (i == 2) trigger = 1'b0;
      rst = (i == 3);
    end
    n_checks++;
    if (rd_cnt != 2 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_counts rd=%0d done=%0d exp 2/0", rd_cnt, done_cnt);
    end
    rd_cnt = 0; done_cnt = 0;
    set_cfg(0, 3, 0);
    trigger = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL restart cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      if (fifo_rd_en) rd_cnt++;
      if (done) done_cnt++;
    end
    trigger = 1'b0;
    n_checks++;
    if (rd_cnt != 3 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL restart_counts rd=%0d done=%0d exp 3/1", rd_cnt, done_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_mask();
    for (int m = 0; m < 2; m++) begin
      mask_en = m[0];
      set_cfg(2, 3, 2);
      @(negedge clk);
      trigger = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL mask%0d cyc %0d obs=%b exp=%b", m, i, obs_vec, exp_vec());
        end
        n_checks++;
        if ((m == 0 && dac_unmask !== 1'b1) || (m == 1 && busy && dac_unmask !== fifo_rd_en)) begin
          n_fail++;
          $display("FAIL mask%0d_unmask cyc %0d unmask=%b rd=%b", m, i, dac_unmask, fifo_rd_en);
        end
`ifdef DAC_SEQ_LOCK_WAVE_EN
        n_checks++;
        if (lock_play !== !busy) begin
          n_fail++;
          $display("FAIL lock_play cyc %0d lock=%b busy=%b", i, lock_play, busy);
        end
`endif
      end
      trigger = 1'b0;
    end
    mask_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max_count();
    set_cfg(64'hFFFF_FFFF, 5, 0);
    trigger = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || fifo_rd_en !== 1'b0 || obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL max_count cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
      trigger = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 1; i <= 1500; i++) begin
      if ($urandom_range(0, 3) == 0) trigger = ~trigger;
      set_cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) mask_en = $urandom_range(0, 1);
      fifo_empty = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d obs=%b exp=%b", i, obs_vec, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_config();
    test_held_trigger();
    test_underrun();
    test_reset_mid();
    test_mask();
    test_max_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
